// File: rtl/mersenne_pkg.sv
// mersenne_pkg: shared FSM states, error codes and reducer step count for the trial-factoring engine
package mersenne_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        CHECK,
        SQR,
        DBL,
        EVAL,
        NEXT,
        DONE
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_P_SMALL = 2'b01;
    localparam logic [1:0] ERR_Q_OVF   = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    // The restoring reducer consumes one dividend bit per cycle, and the
    // dividend is a full square, so it runs this many cycles per q bit.
    localparam int RED_STEPS_PER_QBIT = 2;

endpackage

// File: rtl/mod_reduce.sv
// mod_reduce: bit-serial restoring reduction of a 2*QWIDTH dividend modulo a QWIDTH modulus
module mod_reduce
    import mersenne_pkg::*;
#(
    parameter int QWIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2*QWIDTH-1:0]   dividend,
    input  logic [QWIDTH-1:0]     modulus,
    output logic [QWIDTH-1:0]     remainder,
    output logic                  finished
);

    localparam int STEPS = RED_STEPS_PER_QBIT * QWIDTH;
    localparam int CW    = $clog2(STEPS + 1);

    logic [2*QWIDTH-1:0] div_q, div_d;
    logic [QWIDTH-1:0]   rem_q, rem_d;
    logic [QWIDTH-1:0]   mod_q, mod_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [QWIDTH:0]     trial;
    logic [QWIDTH-1:0]   rem_step;

    // One shift-subtract step per cycle; the final step's result is exposed combinationally with the finished pulse
    always_comb begin
        trial     = {rem_q, div_q[2*QWIDTH-1]};
        rem_step  = (trial >= {1'b0, mod_q}) ? QWIDTH'(trial - {1'b0, mod_q}) : trial[QWIDTH-1:0];
        div_d     = div_q;
        rem_d     = rem_q;
        mod_d     = mod_q;
        cnt_d     = cnt_q;
        if (start) begin
            div_d = dividend;
            rem_d = '0;
            mod_d = modulus;
            cnt_d = CW'(STEPS);
        end else if (cnt_q != '0) begin
            div_d = div_q << 1;
            rem_d = rem_step;
            cnt_d = cnt_q - CW'(1);
        end
        finished  = !start && (cnt_q == CW'(1));
        remainder = rem_step;
    end

    // Reducer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            rem_q <= '0;
            mod_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            rem_q <= rem_d;
            mod_q <= mod_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mersenne_factor_sweep.sv
// mersenne_factor_sweep: sweeps q = 2kp+1 and tests 2^p mod q == 1; MERSENNE_Q_MOD8_FILTER_EN skips q mod 8 not in {1,7}
module mersenne_factor_sweep
    import mersenne_pkg::*;
#(
    parameter int PWIDTH = 32,
    parameter int KWIDTH = 32,
    parameter int QWIDTH = 64
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PWIDTH-1:0] p,
    input  logic [KWIDTH-1:0] k_start,
    input  logic [KWIDTH-1:0] k_count,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [QWIDTH-1:0] factor,
    output logic [KWIDTH-1:0] k_found,
    output logic [1:0]        err
);

    // q is kept wide enough for the exact product and any later +2p so overflow is seen before truncation
    localparam int WW = ((QWIDTH > KWIDTH + PWIDTH + 1) ? QWIDTH : KWIDTH + PWIDTH + 1) + 1;
    localparam int IW = (PWIDTH > 1) ? $clog2(PWIDTH) : 1;
    localparam int CW = $clog2(KWIDTH + 1);

    state_t              state_q, state_d;
    logic [PWIDTH-1:0]   p_q, p_d;
    logic [KWIDTH-1:0]   k_q, k_d;
    logic [KWIDTH-1:0]   rem_q, rem_d;
    logic [WW-1:0]       acc_q, acc_d;
    logic [WW-1:0]       mcand_q, mcand_d;
    logic [KWIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       msb_q, msb_d;
    logic [IW-1:0]       i_q, i_d;
    logic [QWIDTH-1:0]   r_q, r_d;
    logic                sqr_run_q, sqr_run_d;
    logic                found_q, found_d;
    logic [QWIDTH-1:0]   factor_q, factor_d;
    logic [KWIDTH-1:0]   k_found_q, k_found_d;
    logic [1:0]          err_q, err_d;

    logic [IW-1:0]       msb_calc;
    logic                q_ovf;
    logic                q_skip;
    logic [QWIDTH-1:0]   q_cur;
    logic [WW-1:0]       two_p;
    logic [2*QWIDTH-1:0] sq;
    logic [QWIDTH:0]     r2;
    logic [QWIDTH-1:0]   r_dbl;
    logic                red_start;
    logic                red_fin;
    logic                sqr_fin;
    logic [QWIDTH-1:0]   red_rem;

    // Datapath helpers: msb of p, overflow/filter tests on q, the square and the doubling step
    always_comb begin
        msb_calc = '0;
        for (int b = 0; b < PWIDTH; b++)
            if (p_q[b]) msb_calc = IW'(b);
        q_ovf     = |acc_q[WW-1:QWIDTH];
        q_cur     = acc_q[QWIDTH-1:0];
`ifdef MERSENNE_Q_MOD8_FILTER_EN
        q_skip    = (q_cur[2:0] != 3'd1) && (q_cur[2:0] != 3'd7);
`else
        q_skip    = 1'b0;
`endif
        two_p     = WW'({p_q, 1'b0});
        sq        = {{QWIDTH{1'b0}}, r_q} * {{QWIDTH{1'b0}}, r_q};
        r2        = {r_q, 1'b0};
        r_dbl     = (r2 >= {1'b0, q_cur}) ? QWIDTH'(r2 - {1'b0, q_cur}) : r2[QWIDTH-1:0];
        red_start = (state_q == SQR) && !sqr_run_q;
        sqr_fin   = sqr_run_q && red_fin;
    end

    mod_reduce #(
        .QWIDTH(QWIDTH)
    ) u_mod_reduce (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .start    (red_start),
        .dividend (sq),
        .modulus  (q_cur),
        .remainder(red_rem),
        .finished (red_fin)
    );

    // Job sequencing: accept, multiply, per-candidate exponentiation, evaluate, advance; abort overrides last
    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        k_d       = k_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        msb_d     = msb_q;
        i_d       = i_q;
        r_d       = r_q;
        found_d   = found_q;
        factor_d  = factor_q;
        k_found_d = k_found_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    p_d       = p;
                    k_d       = k_start;
                    rem_d     = k_count;
                    acc_d     = WW'(1);
                    mcand_d   = WW'({p, 1'b0});
                    mplier_d  = k_start;
                    cnt_d     = CW'(KWIDTH - 1);
                    found_d   = 1'b0;
                    factor_d  = '0;
                    k_found_d = '0;
                    err_d     = ERR_OK;
                    state_d   = INIT;
                end
            end
            INIT: begin
                acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                msb_d    = msb_calc;
                if (cnt_q == '0) begin
                    err_d   = (p_q[PWIDTH-1:1] == '0) ? ERR_P_SMALL : ERR_OK;
                    state_d = (p_q[PWIDTH-1:1] == '0 || rem_q == '0) ? DONE : CHECK;
                end
            end
            CHECK: begin
                if (q_ovf) begin
                    err_d   = ERR_Q_OVF;
                    state_d = DONE;
                end else if (q_skip) begin
                    state_d = NEXT;
                end else begin
                    r_d     = QWIDTH'(1);
                    i_d     = msb_q;
                    state_d = SQR;
                end
            end
            SQR: begin
                if (sqr_fin) begin
                    r_d = red_rem;
                    if (p_q[i_q]) begin
                        state_d = DBL;
                    end else if (i_q == '0) begin
                        state_d = EVAL;
                    end else begin
                        i_d     = i_q - IW'(1);
                        state_d = SQR;
                    end
                end
            end
            DBL: begin
                r_d     = r_dbl;
                i_d     = (i_q == '0) ? i_q : i_q - IW'(1);
                state_d = (i_q == '0) ? EVAL : SQR;
            end
            EVAL: begin
                if (r_q == QWIDTH'(1) && q_cur > QWIDTH'(1)) begin
                    found_d   = 1'b1;
                    factor_d  = q_cur;
                    k_found_d = k_q;
                    state_d   = DONE;
                end else begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                rem_d   = rem_q - KWIDTH'(1);
                k_d     = k_q + KWIDTH'(1);
                acc_d   = acc_q + two_p;
                state_d = (rem_q == KWIDTH'(1)) ? DONE : CHECK;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE && state_q != DONE) begin
            state_d   = DONE;
            err_d     = ERR_ABORT;
            found_d   = 1'b0;
            factor_d  = '0;
            k_found_d = '0;
        end
        sqr_run_d = (state_q == SQR) && (state_d == SQR) && !sqr_fin;
    end

    // State and datapath registers; reset drops any job in flight without a done pulse
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            p_q       <= '0;
            k_q       <= '0;
            rem_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            msb_q     <= '0;
            i_q       <= '0;
            r_q       <= '0;
            sqr_run_q <= 1'b0;
            found_q   <= 1'b0;
            factor_q  <= '0;
            k_found_q <= '0;
            err_q     <= ERR_OK;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            k_q       <= k_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            msb_q     <= msb_d;
            i_q       <= i_d;
            r_q       <= r_d;
            sqr_run_q <= sqr_run_d;
            found_q   <= found_d;
            factor_q  <= factor_d;
            k_found_q <= k_found_d;
            err_q     <= err_d;
        end
    end

    assign busy    = (state_q != IDLE) && (state_q != DONE);
    assign done    = (state_q == DONE);
    assign found   = found_q;
    assign factor  = factor_q;
    assign k_found = k_found_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mersenne_factor_sweep.sv
// tb_mersenne_factor_sweep: table-driven scoreboard bench for the 64-bit engine plus an 8-bit-q instance for overflow cases
module tb_mersenne_factor_sweep;

    localparam int KW = 32;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start_b = 1'b0;
    logic        start_s = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] p = '0;
    logic [31:0] k_start = '0;
    logic [31:0] k_count = '0;
    logic        sel = 1'b0;

    logic        busy_b, done_b, found_b;
    logic [63:0] factor_b;
    logic [31:0] k_found_b;
    logic [1:0]  err_b;
    logic        busy_s, done_s, found_s;
    logic [7:0]  factor_s;
    logic [31:0] k_found_s;
    logic [1:0]  err_s;

    always #5 sys_clk = ~sys_clk;

    mersenne_factor_sweep #(.PWIDTH(32), .KWIDTH(32), .QWIDTH(64)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_b), .abort(abort),
        .p(p), .k_start(k_start), .k_count(k_count),
        .busy(busy_b), .done(done_b), .found(found_b), .factor(factor_b),
        .k_found(k_found_b), .err(err_b)
    );

    mersenne_factor_sweep #(.PWIDTH(32), .KWIDTH(32), .QWIDTH(8)) dut_s (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_s), .abort(abort),
        .p(p), .k_start(k_start), .k_count(k_count),
        .busy(busy_s), .done(done_s), .found(found_s), .factor(factor_s),
        .k_found(k_found_s), .err(err_s)
    );

    logic        busy_m, done_m, found_m;
    logic [63:0] factor_m;
    logic [31:0] k_found_m;
    logic [1:0]  err_m;
    assign busy_m    = sel ? busy_s : busy_b;
    assign done_m    = sel ? done_s : done_b;
    assign found_m   = sel ? found_s : found_b;
    assign factor_m  = sel ? 64'(factor_s) : factor_b;
    assign k_found_m = sel ? k_found_s : k_found_b;
    assign err_m     = sel ? err_s : err_b;

    typedef struct {
        logic        found;
        logic [63:0] factor;
        logic [31:0] kf;
        logic [1:0]  err;
        int          cycles;
    } exp_t;

    typedef struct {
        bit          sm;
        int          pp;
        int          ks;
        int          kc;
        logic        found;
        logic [63:0] factor;
        int          kf;
        logic [1:0]  err;
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   busy_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: repeated doubling mod q, plus the cycle cost of each stage
    task automatic model(input int pp, input int ks, input int kc, input int qw, output exp_t e);
        longint q, r;
        int msb, pop, lat;
        e.found = 1'b0; e.factor = '0; e.kf = '0; e.err = 2'd0; e.cycles = KW;
        if (pp < 2) begin e.err = 2'd1; return; end
        if (kc == 0) return;
        msb = 0; pop = 0;
        for (int b = 0; b < 32; b++) if (pp[b]) begin msb = b; pop++; end
        lat = 2 + (msb + 1) * (2 * qw + 1) + pop;
        for (int j = 0; j < kc; j++) begin
            q = 2 * longint'(ks + j) * longint'(pp) + 1;
            if (qw < 64 && q >= (longint'(1) << qw)) begin
                e.cycles += 1; e.err = 2'd2; return;
            end
`ifdef MERSENNE_Q_MOD8_FILTER_EN
            if (q % 8 != 1 && q % 8 != 7) begin e.cycles += 2; continue; end
`endif
            r = 1;
            for (int s = 0; s < pp; s++) r = (2 * r) % q;
            e.cycles += lat;
            if (r == 1 && q > 1) begin
                e.found = 1'b1; e.factor = 64'(q); e.kf = ks + j; return;
            end
            e.cycles += 1;
        end
    endtask

    // Scoreboard pop on every done pulse; busy cycles counted per job
    always @(negedge sys_clk) begin : mon
        exp_t e;
        if (!sys_rst_n) busy_cnt = 0;
        else if (busy_m) busy_cnt++;
        if (done_m) begin
            if (sb.size() == 0) chk("unexpected_done", 64'(done_m), 64'd0);
            else begin
                e = sb.pop_front();
                chk("found", 64'(found_m), 64'(e.found));
                chk("factor", factor_m, e.factor);
                chk("k_found", 64'(k_found_m), 64'(e.kf));
                chk("err", 64'(err_m), 64'(e.err));
                chk("busy_cycles", 64'(busy_cnt), 64'(e.cycles));
            end
            busy_cnt = 0;
        end
    end

    task automatic launch(input bit sm, input int pp, input int ks, input int kc, input exp_t e);
        @(negedge sys_clk);
        sel = sm; p = pp; k_start = ks; k_count = kc;
        sb.push_back(e);
        if (sm) start_s = 1'b1; else start_b = 1'b1;
        @(negedge sys_clk);
        start_b = 1'b0; start_s = 1'b0;
    endtask

    task automatic wait_empty(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge sys_clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge sys_clk);
    endtask

    initial begin
        vec_t tv[11];
        exp_t e;
        tv[0]  = '{1'b0, 11,  1,  4, 1'b1, 64'd23,  1,  2'd0};
        tv[1]  = '{1'b0, 11,  2,  3, 1'b1, 64'd89,  4,  2'd0};
        tv[2]  = '{1'b0,  7,  1,  8, 1'b0, 64'd0,   0,  2'd0};
        tv[3]  = '{1'b0, 29,  1, 10, 1'b1, 64'd233, 4,  2'd0};
        tv[4]  = '{1'b1, 11, 12,  1, 1'b0, 64'd0,   0,  2'd2};
        tv[5]  = '{1'b0,  1,  5,  3, 1'b0, 64'd0,   0,  2'd1};
        tv[6]  = '{1'b0, 11,  1,  0, 1'b0, 64'd0,   0,  2'd0};
        tv[7]  = '{1'b1, 11, 10,  3, 1'b0, 64'd0,   0,  2'd2};
        tv[8]  = '{1'b1, 11,  1,  1, 1'b1, 64'd23,  1,  2'd0};
        tv[9]  = '{1'b0, 11,  0,  2, 1'b1, 64'd23,  1,  2'd0};
        tv[10] = '{1'b0,  0,  1,  1, 1'b0, 64'd0,   0,  2'd1};

        repeat (2) @(negedge sys_clk);
        chk("rst_busy", 64'(busy_b), 64'd0);
        chk("rst_done", 64'(done_b), 64'd0);
        chk("rst_found", 64'(found_b), 64'd0);
        chk("rst_factor", factor_b, 64'd0);
        chk("rst_k_found", 64'(k_found_b), 64'd0);
        chk("rst_err", 64'(err_b), 64'd0);
        chk("rst_busy_s", 64'(busy_s), 64'd0);
        sys_rst_n = 1'b1;

        for (int v = 0; v < 11; v++) begin
            model(tv[v].pp, tv[v].ks, tv[v].kc, tv[v].sm ? 8 : 64, e);
            e.found = tv[v].found; e.factor = tv[v].factor; e.kf = tv[v].kf; e.err = tv[v].err;
            launch(tv[v].sm, tv[v].pp, tv[v].ks, tv[v].kc, e);
            wait_empty(20000);
        end

        // Abort in the first square of p=31: busy for exactly 81 cycles, done on the next
        e.found = 1'b0; e.factor = '0; e.kf = '0; e.err = 2'd3; e.cycles = 81;
        launch(1'b0, 31, 1, 1, e);
        repeat (80) @(negedge sys_clk);
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        chk("abort_done_next", 64'(done_b), 64'd1);
        wait_empty(10);

        // A second start during a running job must not disturb it
        model(11, 1, 4, 64, e);
        e.found = 1'b1; e.factor = 64'd23; e.kf = 1; e.err = 2'd0;
        launch(1'b0, 11, 1, 4, e);
        repeat (100) @(negedge sys_clk);
        p = 7; k_start = 1; k_count = 8; start_b = 1'b1;
        @(negedge sys_clk);
        start_b = 1'b0;
        wait_empty(20000);
        chk("found_held", 64'(found_b), 64'd1);
        chk("factor_held", factor_b, 64'd23);

        // Reset while idle clears held results
        sys_rst_n = 1'b0;
        #1;
        chk("rst_idle_found", 64'(found_b), 64'd0);
        chk("rst_idle_factor", factor_b, 64'd0);
        chk("rst_idle_k_found", 64'(k_found_b), 64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Reset mid-job: outputs drop immediately and no done pulse follows
        @(negedge sys_clk);
        sel = 1'b0; p = 29; k_start = 1; k_count = 10; start_b = 1'b1;
        @(negedge sys_clk);
        start_b = 1'b0;
        repeat (50) @(negedge sys_clk);
        chk("midjob_busy", 64'(busy_b), 64'd1);
        sys_rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy_b), 64'd0);
        chk("rst_mid_done", 64'(done_b), 64'd0);
        chk("rst_mid_err", 64'(err_b), 64'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        // Engine recovers after the mid-job reset
        model(29, 1, 10, 64, e);
        e.found = 1'b1; e.factor = 64'd233; e.kf = 4; e.err = 2'd0;
        launch(1'b0, 29, 1, 10, e);
        wait_empty(20000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
